// File: rtl/pc_fetch_ctrl_if.sv
// -----------------------------------------------------------------------------
// pc_fetch_ctrl_if
//
// Purpose:
//   Bundles the instruction-fetch bus between the PC/fetch sequencer, the
//   instruction ROM and the IF/ID register.
//
// Signals:
//   inst_address [31:0] - fetch address, also the PC of the delivered instruction
//   ce                  - fetch enable toward the instruction ROM
//   rfin_c              - ROM read finished, data valid in the same cycle
//   pc_valid            - instruction on the ROM output is valid for IF/ID
//   fetch_adel          - misaligned-fetch exception tag
//
// Modports:
//   master - the fetch sequencer (drives address/enables, receives rfin_c)
//   slave  - the ROM / IF-ID side (receives address/enables, drives rfin_c)
// -----------------------------------------------------------------------------
interface pc_fetch_ctrl_if;
    logic [31:0] inst_address;
    logic        ce;
    logic        rfin_c;
    logic        pc_valid;
    logic        fetch_adel;

    modport master (
        output inst_address,
        output ce,
        output pc_valid,
        output fetch_adel,
        input  rfin_c
    );

    modport slave (
        input  inst_address,
        input  ce,
        input  pc_valid,
        input  fetch_adel,
        output rfin_c
    );
endinterface

// File: rtl/pc_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// pc_fetch_ctrl
//
// Purpose:
//   Program-counter and fetch-sequencing stage in front of the instruction
//   ROM. Owns the PC, issues fetches, waits for the ROM read-finish strobe and
//   presents a valid instruction to IF/ID. Handles hazard stalls, delay-slot
//   aware branch redirects and exception flushes.
//
// Parameters:
//   RESET_PC      - first fetch address after reset
//
// Ports:
//   clk           - single clock, all state on the rising edge
//   rst           - synchronous active-high reset
//   stall         - hazard hold; the delivered instruction is not consumed
//   branch_flag   - branch resolved in ID; current fetch is its delay slot
//   branch_target - redirect address, sampled with branch_flag
//   flush         - exception/ERET flush, highest priority
//   flush_pc      - restart address, sampled with flush
//   fbus          - fetch bus (master side): inst_address, ce, pc_valid,
//                   fetch_adel out; rfin_c in
//
// Configuration macro:
//   FETCH_ALIGN_CHECK_EN - when defined, a misaligned PC in FETCH issues no
//                          read and is delivered at once tagged fetch_adel.
//                          When undefined, fetch_adel is 0 and the low two
//                          address bits are forced to zero.
// -----------------------------------------------------------------------------
module pc_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              branch_flag,
    input  logic [31:0]       branch_target,
    input  logic              flush,
    input  logic [31:0]       flush_pc,
    pc_fetch_ctrl_if.master   fbus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2,
        ST_DRAIN = 2'd3
    } state_e;

    // Sequential successor of a PC; wraps naturally modulo 2^32.
    function automatic logic [31:0] seq_next(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

    state_e      state_q,      state_d;
    logic [31:0] pc_q,         pc_d;
    logic        redir_pend_q, redir_pend_d;
    logic [31:0] redir_pc_q,   redir_pc_d;

    logic        misalign_s;    // current PC is not word aligned (check build only)
    logic        present_s;     // an instruction is on offer to IF/ID this cycle
    logic        deliver_s;     // offered instruction is consumed this cycle
    logic [31:0] next_pc_s;     // PC after a consumed delivery with no new branch

`ifdef FETCH_ALIGN_CHECK_EN
    // Misalignment detection on the live PC.
    always_comb begin
        misalign_s = (pc_q[1:0] != 2'b00);
    end
`else
    // Alignment checking is compiled out; the word containing the PC is fetched.
    always_comb begin
        misalign_s = 1'b0;
    end
`endif

    // Delivery qualification and the default successor PC.
    always_comb begin
        present_s = 1'b0;
        case (state_q)
            // A misaligned fetch needs no ROM response to be delivered.
            ST_FETCH: present_s = fbus.rfin_c | misalign_s;
            // The ROM keeps driving the last instruction while held.
            ST_HOLD:  present_s = 1'b1;
            ST_IDLE:  present_s = 1'b0;
            ST_DRAIN: present_s = 1'b0;
            default:  present_s = 1'b0;
        endcase

        deliver_s = present_s & ~stall;

        // A pending redirect wins over the sequential successor exactly once.
        if (redir_pend_q) begin
            next_pc_s = redir_pc_q;
        end else begin
            next_pc_s = seq_next(pc_q);
        end
    end

    // Next-state, PC and redirect-register update.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        redir_pend_d = redir_pend_q;
        redir_pc_d   = redir_pc_q;

        case (state_q)
            ST_IDLE: begin
                state_d = ST_FETCH;
                if (flush) begin
                    pc_d         = flush_pc;
                    redir_pend_d = 1'b0;
                end else begin
                    pc_d = pc_q;
                end
            end

            ST_FETCH, ST_HOLD: begin
                if (flush) begin
                    redir_pend_d = 1'b0;
                    if (present_s) begin
                        // Nothing outstanding at the ROM: restart immediately.
                        pc_d    = flush_pc;
                        state_d = ST_FETCH;
                    end else begin
                        // A read is in flight; let it retire before refetching.
                        redir_pc_d = flush_pc;
                        state_d    = ST_DRAIN;
                    end
                end else if (deliver_s) begin
                    state_d = ST_FETCH;
                    if (redir_pend_q) begin
                        pc_d         = next_pc_s;
                        redir_pend_d = 1'b0;
                    end else if (branch_flag) begin
                        // The delay slot is the instruction consumed right now,
                        // so jump straight to the target without parking it.
                        pc_d = branch_target;
                    end else begin
                        pc_d = next_pc_s;
                    end
                end else begin
                    if (present_s) begin
                        state_d = ST_HOLD;
                    end else begin
                        state_d = state_q;
                    end
                    // Park the target until the delay slot is consumed; a
                    // second branch before that is an illegal delay-slot branch.
                    if (branch_flag && !redir_pend_q) begin
                        redir_pend_d = 1'b1;
                        redir_pc_d   = branch_target;
                    end else begin
                        redir_pend_d = redir_pend_q;
                    end
                end
            end

            ST_DRAIN: begin
                // A repeat flush only retargets; the newest target always wins.
                if (flush) begin
                    redir_pc_d = flush_pc;
                end else begin
                    redir_pc_d = redir_pc_q;
                end
                if (fbus.rfin_c) begin
                    state_d = ST_FETCH;
                    if (flush) begin
                        pc_d = flush_pc;
                    end else begin
                        pc_d = redir_pc_q;
                    end
                end else begin
                    state_d = ST_DRAIN;
                end
            end

            default: begin
                state_d      = ST_IDLE;
                pc_d         = RESET_PC;
                redir_pend_d = 1'b0;
                redir_pc_d   = 32'h0000_0000;
            end
        endcase
    end

    // State, PC and redirect registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            pc_q         <= RESET_PC;
            redir_pend_q <= 1'b0;
            redir_pc_q   <= 32'h0000_0000;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            redir_pend_q <= redir_pend_d;
            redir_pc_q   <= redir_pc_d;
        end
    end

    // Fetch-bus outputs; pc_valid follows rfin_c with no added latency.
    always_comb begin
        case (state_q)
            ST_IDLE:  fbus.ce = 1'b0;
            ST_FETCH: fbus.ce = ~misalign_s;
            ST_HOLD:  fbus.ce = ~misalign_s;
            ST_DRAIN: fbus.ce = 1'b1;
            default:  fbus.ce = 1'b0;
        endcase

        // A flush cycle never hands an instruction to IF/ID.
        fbus.pc_valid = present_s & ~flush;

`ifdef FETCH_ALIGN_CHECK_EN
        fbus.fetch_adel   = present_s & ~flush & misalign_s;
        fbus.inst_address = pc_q;
`else
        fbus.fetch_adel   = 1'b0;
        fbus.inst_address = {pc_q[31:2], 2'b00};
`endif
    end

endmodule

// File: doc/pc_fetch_ctrl.md
# pc_fetch_ctrl

Program-counter and fetch-sequencing stage that sits directly upstream of the instruction ROM interface. It owns the PC and drives the fetch address and chip-enable. It waits for the memory read-finish strobe and delivers a valid pulse to IF/ID. It also handles pipeline stalls, delay-slot-aware branch redirects and exception flushes.

## Interface
- `RESET_PC`, default 32'hBFC0_0000: first fetch address after reset.
- `clk` in 1: single clock, all state on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `stall` in 1: hazard-unit hold. The delivered instruction must not be consumed while high.
- `branch_flag` in 1: branch resolved in ID. The current fetch is its delay slot.
- `branch_target` in 32: redirect address, sampled when `branch_flag`=1.
- `flush` in 1: exception/ERET flush. Highest priority.
- `flush_pc` in 32: restart address, sampled when `flush`=1.
- `rfin_c` in 1: instruction memory read finished. Data is valid in the same cycle.
- `inst_address` out 32: fetch address. It also serves as the PC of the delivered instruction.
- `ce` out 1: fetch enable toward the instruction ROM.
- `pc_valid` out 1: the instruction on the ROM output is valid for IF/ID this cycle.
- `fetch_adel` out 1: misaligned-fetch exception tag. Behaviour is set under Configuration.

## Operation
- State register encodes IDLE, FETCH, HOLD, DRAIN. PC register `pc` drives `inst_address`.
- Redirect registers: `redir_pend` (1 bit) and `redir_pc` (32 bits).
- IDLE:
  - `ce`=0, `pc_valid`=0.
  - Next state is FETCH unconditionally. `pc` is already RESET_PC.
- FETCH:
  - `ce`=1. `pc_valid` = `rfin_c`, combinational.
  - `rfin_c`=0: stay in FETCH, `pc` unchanged.
  - `rfin_c`=1 and `stall`=0: `pc` <= next, stay in FETCH.
  - `rfin_c`=1 and `stall`=1: go to HOLD, `pc` unchanged.
- HOLD:
  - `ce`=1, `pc_valid`=1 continuously. The ROM output holds its last instruction.
  - When `stall`=0: `pc` <= next, go to FETCH.
- next: if `redir_pend`, use `redir_pc` and clear `redir_pend`. Otherwise use `pc`+4, modulo 2^32 (0xFFFF_FFFC wraps to 0x0000_0000).
- branch_flag rules:
  - In FETCH or HOLD with no pending redirect: set `redir_pend`, `redir_pc` <= `branch_target`.
  - If `branch_flag` coincides with a delivery (`rfin_c`=1 and `stall`=0 in FETCH, or `stall`=0 in HOLD): `pc` <= `branch_target` directly and `redir_pend` stays 0. The delay slot is the instruction delivered that cycle.
  - `branch_flag` while `redir_pend`=1 is ignored. A branch in a delay slot is illegal.
- flush rules (override branch and stall):
  - `redir_pend` <= 0 and `pc_valid` is forced to 0 in the flush cycle.
  - In FETCH with `rfin_c`=0: go to DRAIN and latch `flush_pc` into `redir_pc`. DRAIN keeps `ce`=1 and `pc_valid`=0 until `rfin_c`=1, then sets `pc` <= `redir_pc` and goes to FETCH.
  - In FETCH with `rfin_c`=1, or in HOLD: `pc` <= `flush_pc`, go to FETCH.
  - In DRAIN: `redir_pc` <= the new `flush_pc`.
  - In IDLE: `pc` <= `flush_pc`, go to FETCH.
- A second flush during DRAIN updates the target only.

## Timing
- Reset values: state IDLE, `pc`=`inst_address`=RESET_PC, `ce`=0, `pc_valid`=0, `fetch_adel`=0, `redir_pend`=0, `redir_pc`=0.
- `rst` sampled high at any edge, including mid-read or mid-DRAIN, abandons all activity. The outstanding `rfin_c` is ignored.
- The first edge with `rst`=0 moves to FETCH. `ce`=1 in the following cycle.
- `pc_valid` is combinational from `rfin_c` and state, giving zero added latency.
- Address changes occur only on the edge after delivery. Back-to-back single-cycle reads yield one instruction per cycle.
- `inst_address` is stable whenever `pc_valid`=1.

## Configuration
- `FETCH_ALIGN_CHECK_EN` defined:
  - In FETCH with `pc[1:0]`≠0, `ce`=0 and no read is issued.
  - `pc_valid`=1 and `fetch_adel`=1 in the same cycle, without `rfin_c`.
  - Stall and HOLD rules apply as for a normal delivery.
  - The pipeline is expected to respond with `flush`.
- `FETCH_ALIGN_CHECK_EN` undefined:
  - `fetch_adel` is tied 0.
  - `inst_address[1:0]` is forced to 00. Misaligned targets fetch the word containing them.

## Test plan
- Reset release, `rfin_c` asserted every FETCH cycle → `inst_address` 0xBFC00000, 0xBFC00004, 0xBFC00008 on consecutive cycles, with `pc_valid`=1 each cycle.
- `rfin_c` delayed 3 cycles with `stall`=1 for 2 cycles at delivery → address held at 0xBFC00004. `pc_valid` stays high through HOLD, then advances to 0xBFC00008.
- `branch_flag` with target 0x80001000 while fetching 0xBFC00008 and `rfin_c` late → 0xBFC00008 delivered (delay slot), next address 0x80001000. A second `branch_flag` while pending is ignored.
- `flush` to 0xBFC00380 mid-read → DRAIN with `pc_valid`=0 when `rfin_c` returns, then fetch at 0xBFC00380. `rst` asserted in DRAIN → IDLE, `ce`=0.
- PC at 0xFFFFFFFC → the next sequential fetch is 0x00000000.
- With `FETCH_ALIGN_CHECK_EN`, branch to 0x80000002 → `ce`=0, `pc_valid`=1, `fetch_adel`=1. Without it → `inst_address`=0x80000000.
